// File: rtl/mem_access_sequencer_if.sv
// Handshake bundle between the CPU core and the memory access sequencer.
// Carries the request lines and the sequencer's registered memory-manager outputs.
// No flow control beyond the request/busy/done handshake itself.
//
// master: the core side (drives requests and reg_last, observes status).
// slave : the sequencer (samples requests, drives counter/strobe/status).
interface mem_access_sequencer_if #(
    parameter int CNT_W     = 6,
    parameter int REG_IDX_W = 4
);
    logic                 fetch_req;
    logic                 store_req;
    logic                 load_req;
    logic [REG_IDX_W-1:0] reg_last;
    logic [CNT_W-1:0]     address_counter;
    logic                 write_enable;
    logic [REG_IDX_W-1:0] write_count;
    logic                 busy;
    logic                 opcode_valid;
    logic                 transfer_done;

    modport master (
        output fetch_req, store_req, load_req, reg_last,
        input  address_counter, write_enable, write_count,
        input  busy, opcode_valid, transfer_done
    );

    modport slave (
        input  fetch_req, store_req, load_req, reg_last,
        output address_counter, write_enable, write_count,
        output busy, opcode_valid, transfer_done
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences opcode fetch and bulk register load/store steps for the memory manager.
// Latency: fetch -> opcode_valid 3 edges after accept; load/store -> transfer_done N+3 edges after accept.
// Backpressure: requests are accepted only while idle; requests arriving while busy are dropped.
//
// Ports: clk, rst (async, active-high); bus (slave modport) carries
//   fetch_req/store_req/load_req/reg_last in, and address_counter,
//   write_enable, write_count, busy, opcode_valid, transfer_done out.
//   All outputs are registered.
module mem_access_sequencer #(
    parameter int CNT_W     = 6,
    parameter int REG_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 we, we_nxt;
    logic [REG_IDX_W-1:0] wc, wc_nxt;
    logic                 busy_r, busy_nxt;
    logic                 ov, ov_nxt;
    logic                 td, td_nxt;

    // Final counter value of a transfer: N+1, so that the manager's one-cycle
    // registered address/data path has captured/written byte N on that edge.
    logic [CNT_W-1:0]     last_step;
    assign last_step = CNT_W'(wc) + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            we     <= 1'b0;
            wc     <= '0;
            busy_r <= 1'b0;
            ov     <= 1'b0;
            td     <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            we     <= we_nxt;
            wc     <= wc_nxt;
            busy_r <= busy_nxt;
            ov     <= ov_nxt;
            td     <= td_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = 1'b0;
        wc_nxt    = wc;
        busy_nxt  = busy_r;
        ov_nxt    = 1'b0;
        td_nxt    = 1'b0;
        case (state)
            // The done-pulse cycle is already IDLE, so a waiting request is
            // taken on that edge with no dead cycle in between.
            IDLE: begin
                if (bus.store_req) begin
                    state_nxt = STORE;
                    wc_nxt    = bus.reg_last;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (bus.load_req) begin
                    state_nxt = LOAD;
                    wc_nxt    = bus.reg_last;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (bus.fetch_req) begin
                    state_nxt = FETCH;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            // Counter bit 0 selects the high (0) then low (1) opcode byte.
            FETCH: begin
                if (cnt == '0) begin
                    cnt_nxt = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ov_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            // Store strobes write_enable on counter 1..N+1: the manager's
            // address/data are one cycle behind the counter.
            LOAD, STORE: begin
                if (cnt == last_step) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    td_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    we_nxt  = (state == STORE);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.address_counter = cnt;
    assign bus.write_enable    = we;
    assign bus.write_count     = wc;
    assign bus.busy            = busy_r;
    assign bus.opcode_valid    = ov;
    assign bus.transfer_done   = td;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: per-cycle comparison against a
// trace model, plus literal checks on counts, pulses and reset behaviour.
module tb_mem_access_sequencer;
    localparam int CNT_W     = 6;
    localparam int REG_IDX_W = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_access_sequencer_if #(.CNT_W(CNT_W), .REG_IDX_W(REG_IDX_W)) bus ();

    mem_access_sequencer #(.CNT_W(CNT_W), .REG_IDX_W(REG_IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             we;
        logic             busy;
        logic             ov;
        logic             td;
    } exp_t;

    function automatic exp_t mk(input int c, input bit w, input bit b, input bit o, input bit t);
        exp_t e;
        e.cnt  = CNT_W'(c);
        e.we   = w;
        e.busy = b;
        e.ov   = o;
        e.td   = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: when idle and a request is seen, the whole expected output trace
    // of the operation is queued; one entry is consumed per clock edge.
    exp_t q[$];
    exp_t cur = '0;
    int   wc_exp = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                cur    = '0;
                wc_exp = 0;
            end else begin
                if (q.size() == 0) begin
                    if (bus.store_req || bus.load_req) begin
                        int n;
                        n      = int'(bus.reg_last);
                        wc_exp = n;
                        for (int k = 0; k <= n + 1; k++)
                            q.push_back(mk(k, bus.store_req && k >= 1, 1'b1, 1'b0, 1'b0));
                        q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b1));
                    end else if (bus.fetch_req) begin
                        q.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b0));
                        q.push_back(mk(1, 1'b0, 1'b1, 1'b0, 1'b0));
                        q.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b0));
                    end
                end
                if (q.size() > 0) cur = q.pop_front();
                else              cur = '0;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_address_counter", 32'(bus.address_counter), 32'(cur.cnt));
            check("cyc_write_enable",    32'(bus.write_enable),    32'(cur.we));
            check("cyc_busy",            32'(bus.busy),            32'(cur.busy));
            check("cyc_opcode_valid",    32'(bus.opcode_valid),    32'(cur.ov));
            check("cyc_transfer_done",   32'(bus.transfer_done),   32'(cur.td));
            check("cyc_write_count",     32'(bus.write_count),     32'(wc_exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Fetch with literal expectations: counter 0,1 while busy, then opcode_valid.
    task automatic fetch_check(input string tag, input int wc_hold);
        @(negedge clk);
        bus.fetch_req = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        check({tag, "_c1_busy"}, 32'(bus.busy), 1);
        check({tag, "_c1_cnt"},  32'(bus.address_counter), 0);
        @(negedge clk);
        check({tag, "_c2_busy"}, 32'(bus.busy), 1);
        check({tag, "_c2_cnt"},  32'(bus.address_counter), 1);
        check({tag, "_c2_ov"},   32'(bus.opcode_valid), 0);
        @(negedge clk);
        check({tag, "_c3_ov"},   32'(bus.opcode_valid), 1);
        check({tag, "_c3_busy"}, 32'(bus.busy), 0);
        check({tag, "_c3_cnt"},  32'(bus.address_counter), 0);
        check({tag, "_wc"},      32'(bus.write_count), 32'(wc_hold));
        @(negedge clk);
        check({tag, "_c4_ov"},   32'(bus.opcode_valid), 0);
    endtask

    // Load/store: count busy and write cycles, then expect the done pulse.
    task automatic run_xfer(input bit st, input bit ld, input int rl, input int mid_rl,
                            input int exp_busy, input int exp_we, input int exp_wc,
                            input string tag);
        int nb;
        int nw;
        int guard;
        @(negedge clk);
        bus.store_req = st;
        bus.load_req  = ld;
        bus.reg_last  = REG_IDX_W'(rl);
        @(negedge clk);
        bus.store_req = 1'b0;
        bus.load_req  = 1'b0;
        bus.reg_last  = REG_IDX_W'(mid_rl);
        nb = 0;
        nw = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 60) begin
            nb++;
            if (bus.write_enable === 1'b1) nw++;
            if (bus.write_count !== REG_IDX_W'(exp_wc)) nw += 100;
            @(negedge clk);
            guard++;
        end
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({tag, "_write_cycles"}, 32'(nw), 32'(exp_we));
        check({tag, "_done_pulse"}, 32'(bus.transfer_done), 1);
        check({tag, "_write_count"}, 32'(bus.write_count), 32'(exp_wc));
        @(negedge clk);
        check({tag, "_done_cleared"}, 32'(bus.transfer_done), 0);
    endtask

    initial begin
        int nb;
        int guard;
        rst           = 1'b0;
        bus.fetch_req = 1'b0;
        bus.store_req = 1'b0;
        bus.load_req  = 1'b0;
        bus.reg_last  = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_cnt",  32'(bus.address_counter), 0);
        check("reset_wc",   32'(bus.write_count), 0);
        check("reset_we",   32'(bus.write_enable), 0);

        fetch_check("fetch1", 0);
        run_xfer(1'b1, 1'b0, 3, 3, 5, 4, 3, "store3");
        run_xfer(1'b0, 1'b1, 15, 15, 17, 0, 15, "load15");
        run_xfer(1'b1, 1'b0, 0, 9, 2, 1, 0, "store0_mid9");
        run_xfer(1'b0, 1'b1, 0, 0, 2, 0, 0, "load0");

        // Store and fetch on the same edge: store wins, fetch follows in the done cycle.
        @(negedge clk);
        bus.store_req = 1'b1;
        bus.fetch_req = 1'b1;
        bus.reg_last  = 4'd1;
        @(negedge clk);
        bus.store_req = 1'b0;
        check("prio_store_taken_we", 32'(bus.write_enable), 0);
        check("prio_store_wc", 32'(bus.write_count), 1);
        nb = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 20) begin
            nb++;
            @(negedge clk);
            guard++;
        end
        check("prio_store_busy_cycles", 32'(nb), 3);
        check("prio_store_done", 32'(bus.transfer_done), 1);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        check("b2b_fetch_busy", 32'(bus.busy), 1);
        check("b2b_fetch_cnt0", 32'(bus.address_counter), 0);
        @(negedge clk);
        check("b2b_fetch_cnt1", 32'(bus.address_counter), 1);
        @(negedge clk);
        check("b2b_fetch_ov", 32'(bus.opcode_valid), 1);
        check("b2b_fetch_wc_held", 32'(bus.write_count), 1);

        // Reset at counter=2 of a store with x=5.
        @(negedge clk);
        bus.store_req = 1'b1;
        bus.reg_last  = 4'd5;
        @(negedge clk);
        bus.store_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_pre_cnt", 32'(bus.address_counter), 2);
        check("abort_pre_we",  32'(bus.write_enable), 1);
        rst = 1'b1;
        #1;
        check("abort_cnt",  32'(bus.address_counter), 0);
        check("abort_we",   32'(bus.write_enable), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_wc",   32'(bus.write_count), 0);
        check("abort_td",   32'(bus.transfer_done), 0);
        check("abort_ov",   32'(bus.opcode_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_no_done", 32'(bus.transfer_done), 0);
        fetch_check("fetch_after_abort", 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Control stage directly upstream of the memory manager. Drives its `address_counter`, `write_enable` and `write_count` inputs.
- Sequences three operation types:
  - 2-cycle opcode fetch.
  - Bulk register store to memory at I (FX55).
  - Bulk register load from memory at I (FX65).
- Gives the CPU core a simple request/busy/done handshake, so the core never reasons about the manager's one-cycle registered address/data pipeline.

Parameters:
- CNT_W, 6, width of `address_counter` output; must be >= 5.
- REG_IDX_W, 4, width of register-index / `write_count` field (16 registers).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- fetch_req  input  1  request opcode fetch at current PC; level-sampled in IDLE.
- store_req  input  1  request store of V0..Vx to memory at I.
- load_req  input  1  request load of memory at I into V0..Vx.
- reg_last  input  REG_IDX_W  x, index of last register in transfer; sampled on request acceptance.
- address_counter  output  CNT_W  step counter to memory manager.
- write_enable  output  1  memory write strobe to memory manager.
- write_count  output  REG_IDX_W  latched x, held stable for whole operation.
- busy  output  1  high while an operation is in progress.
- opcode_valid  output  1  one-cycle pulse: manager's opcode register holds the new instruction.
- transfer_done  output  1  one-cycle pulse: load/store finished; read buffer valid (load) or memory updated (store).

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including `address_counter`, `write_enable`, `write_count`, `busy`, `opcode_valid` and `transfer_done`.
- States: IDLE, FETCH, LOAD, STORE. All outputs are registered.
- Request acceptance (IDLE only):
  - Priority when several requests are high on the same edge: store_req > load_req > fetch_req.
  - Requests while busy are ignored, not queued.
  - On accept: `write_count` <= `reg_last` (load/store only; unchanged for fetch), `busy` <= 1, `address_counter` <= 0, enter op state.
- FETCH:
  - `address_counter` = 0 in first cycle, 1 in second cycle.
  - At the end of the second cycle: counter <= 0, busy <= 0, `opcode_valid` <= 1 for exactly one cycle, state -> IDLE.
  - Opcode fetch latency from accept edge = 3 edges to `opcode_valid` high.
- LOAD, with N = latched `write_count`:
  - Counter steps 0,1,...,N+1, incrementing by 1 per cycle (N+2 cycles). `write_enable` stays 0.
  - The manager captures byte k on the edge where the counter = k+1. After the edge at counter=N+1: counter <= 0, busy <= 0, `transfer_done` pulse, IDLE.
- STORE:
  - Same counter sequence as LOAD.
  - `write_enable` = 1 exactly while counter is in 1..N+1, to match the manager's one-cycle registered address/data.
  - `write_enable` is 0 at counter=0 and after completion.
  - `transfer_done` pulse after the last write cycle.
- Pulse cycle: state is already IDLE, so a new request present in the pulse cycle is accepted on that edge (back-to-back ops, no dead cycle).
- N=0 (x=0): 2 counter cycles (0,1); one write (store) or one capture (load).
- N=15: counter reaches 16, which still fits in CNT_W=6; no wrap.
  - Upper counter bits above bit 3 are 0 except at the N=15 final step.
- Counter never exceeds N+1; no wrap-around within an op.
- `reg_last` changes mid-operation have no effect.
- `address_counter[0]` alternates 0/1 during FETCH, matching the manager's high/low opcode byte select.
- Reset mid-operation aborts immediately:
  - `write_enable` drops asynchronously.
  - No done pulse is emitted.
  - A partial store may have written bytes 0..k; this is acceptable.

Test Plan:
- Reset, then fetch_req=1 for one cycle → counter 0,1 over two cycles, `busy`=1 for 2 cycles, `opcode_valid`=1 on the 3rd cycle, then counter=0.
- store_req with reg_last=3 → counter 0..4, `write_enable`=1 at counter 1,2,3,4 (4 writes), `transfer_done` pulse next cycle, `write_count`=3 held throughout.
- load_req with reg_last=15 → counter 0..16, `write_enable` never high, `transfer_done` after 17 busy cycles.
- store_req and fetch_req high on the same edge → STORE taken; fetch_req still high in the done cycle → FETCH starts immediately on that edge.
- reg_last=0 store → exactly one `write_enable` cycle (counter=1); reg_last changed to 9 mid-op has no effect.
- rst asserted at counter=2 of a store with x=5 → all outputs 0 without waiting for an edge; no `transfer_done`; next fetch_req behaves as after reset.
